// File: rtl/mem_wb_sequencer.sv
// Memory/writeback sequencer: issues one load/store at a time, drives the
// writeback mux select and register-file write strobe, flags sticky errors.
module mem_wb_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [1:0]  ex_op,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_sel,
   output logic [31:0] wb_result,
   output logic [31:0] wb_dm,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   input  logic        err_clr,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
   typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_RSV} op_t;

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   op_t        op_q;
   logic [7:0] wait_cnt;
   logic       accept, is_mem_op, aligned;
   logic       go_alu, go_access, bad_op, acc_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (go_alu)         state_nxt = WB;
            else if (go_access) state_nxt = ACCESS;
         end
         ACCESS: begin
            if (mem_ready)        state_nxt = (op_q == OP_LOAD) ? WB : IDLE;
            else if (acc_timeout) state_nxt = IDLE;
         end
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ex_ready    = (state == IDLE);
      accept      = ex_ready && ex_valid;
      is_mem_op   = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
      aligned     = (ex_result[1:0] == 2'b00);
      go_alu      = accept && (ex_op == OP_ALU);
      go_access   = accept && is_mem_op && aligned;
      bad_op      = accept && ((ex_op == OP_RSV) || (is_mem_op && !aligned));
      acc_timeout = (state == ACCESS) && !mem_ready && (wait_cnt == TIMEOUT_M1);
   end

   // Registered outputs are loaded with the values they must show in the
   // cycle after the transition edge, so every output but ex_ready is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_ALU;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_sel    <= 1'b0;
         wb_result <= '0;
         wb_dm     <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         err       <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         if (accept) begin
            wb_result <= ex_result;
            mem_addr  <= ex_result;
            mem_wdata <= ex_wdata;
            rf_waddr  <= ex_rd;
            op_q      <= op_t'(ex_op);
         end
         if (go_alu) begin
            wb_sel <= 1'b0;
            rf_we  <= (ex_rd != '0);
         end
         if (go_access) begin
            mem_req  <= 1'b1;
            mem_we   <= (ex_op == OP_STORE);
            wait_cnt <= '0;
         end
         if (state == ACCESS) begin
            if (mem_ready) begin
               mem_req <= 1'b0;
               if (op_q == OP_LOAD) begin
                  wb_dm  <= mem_rdata;
                  wb_sel <= 1'b1;
                  rf_we  <= (rf_waddr != '0);
               end
            end else if (acc_timeout) begin
               mem_req <= 1'b0;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
         if (bad_op || acc_timeout) err <= 1'b1;
         else if (err_clr)          err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Self-checking bench for mem_wb_sequencer: directed table, random
// transactions against a transaction-level model, and reset/err_clr sequences.
module tb_mem_wb_sequencer;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic [1:0]  ex_op;
   logic [31:0] ex_result, ex_wdata;
   logic [4:0]  ex_rd;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        wb_sel, rf_we, err_clr, err;
   logic [31:0] wb_result, wb_dm;
   logic [4:0]  rf_waddr;

   int vectors = 0;
   int miscompares = 0;
   logic errm = 1'b0;

   mem_wb_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_result(ex_result), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_sel(wb_sel), .wb_result(wb_result), .wb_dm(wb_dm),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .err_clr(err_clr), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] res;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int unsigned wt;      // no-ready cycles before mem_ready
      logic [31:0] rdata;
      logic        clr;
      int unsigned e_req;
      int unsigned e_rf;
      int unsigned e_lat;   // cycles after accept until ex_ready is high again
      logic        e_err;
      logic        e_sel;
      logic [31:0] e_val;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic vec_t model(input vec_t v, input logic err_prev);
      vec_t r = v;
      bit mem_op = (v.op == 2'd1) || (v.op == 2'd2);
      bit bad    = (v.op == 2'd3) || (mem_op && (v.res[1:0] != 2'b00));
      bit tmo    = mem_op && !bad && (v.wt >= TO);
      bit wback  = !bad && !tmo && ((v.op == 2'd0) || (v.op == 2'd1));
      r.e_req = (!mem_op || bad) ? 0 : (tmo ? TO : v.wt + 1);
      r.e_rf  = (wback && (v.rd != 5'd0)) ? 1 : 0;
      if (bad)                r.e_lat = 1;
      else if (v.op == 2'd0)  r.e_lat = 2;
      else if (tmo)           r.e_lat = TO + 1;
      else if (v.op == 2'd1)  r.e_lat = v.wt + 3;
      else                    r.e_lat = v.wt + 2;
      r.e_err = (bad || tmo) ? 1'b1 : (err_prev && !v.clr);
      r.e_sel = (v.op == 2'd1);
      r.e_val = (v.op == 2'd1) ? v.rdata : v.res;
      return r;
   endfunction

   // Entered and left at a negedge with the DUT in IDLE.
   task automatic run_vec(input string tag, input vec_t v);
      int unsigned req = 0, rfc = 0, lat = 0, bad_mem = 0, c = 0;
      logic [4:0]  g_waddr = '0;
      logic        g_sel = 1'b0;
      logic [31:0] g_val = '0;
      bit done = 0;
      chk({tag, " ready_at_start"}, 32'(ex_ready), 32'd1);
      ex_valid = 1'b1; ex_op = v.op; ex_result = v.res; ex_wdata = v.wdata;
      ex_rd = v.rd; err_clr = v.clr;
      mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0; err_clr = 1'b0;
      ex_op = 2'($urandom); ex_result = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
      while (!done && c < 60) begin
         c++;
         if (mem_req) begin
            req++;
            if (mem_we !== (v.op == 2'd2) || mem_addr !== v.res ||
                (v.op == 2'd2 && mem_wdata !== v.wdata)) bad_mem++;
            mem_ready = (req == v.wt + 1);
            mem_rdata = mem_ready ? v.rdata : $urandom;
         end else begin
            mem_ready = 1'($urandom % 2);
            mem_rdata = $urandom;
         end
         if (rf_we) begin
            rfc++;
            g_waddr = rf_waddr;
            g_sel   = wb_sel;
            g_val   = wb_sel ? wb_dm : wb_result;
         end
         if (ex_ready) begin
            lat  = c;
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, " completed"}, 32'(done), 32'd1);
      chk({tag, " req_cycles"}, req, v.e_req);
      chk({tag, " rf_we_cycles"}, rfc, v.e_rf);
      chk({tag, " latency"}, lat, v.e_lat);
      chk({tag, " err"}, 32'(err), 32'(v.e_err));
      if (v.e_req != 0) chk({tag, " mem_signals"}, bad_mem, 0);
      if (v.e_rf != 0) begin
         chk({tag, " rf_waddr"}, 32'(g_waddr), 32'(v.rd));
         chk({tag, " wb_sel"}, 32'(g_sel), 32'(v.e_sel));
         chk({tag, " wb_value"}, g_val, v.e_val);
      end
      errm = err;
      mem_ready = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      vec_t v;
      //          op     res           wdata         rd  wt   rdata         clr  req rf lat err sel val
      tbl[0]  = '{2'd0, 32'h0000_1234, 32'h0,        5'd5,  0, 32'h0,        1'b0, 0, 1, 2, 1'b0, 1'b0, 32'h0000_1234};
      tbl[1]  = '{2'd1, 32'h0000_0100, 32'h0,        5'd7,  3, 32'hDEAD_BEEF, 1'b0, 4, 1, 6, 1'b0, 1'b1, 32'hDEAD_BEEF};
      tbl[2]  = '{2'd2, 32'h0000_0200, 32'hA5A5_A5A5, 5'd3, 0, 32'h0,        1'b0, 1, 0, 2, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{2'd1, 32'h0000_0102, 32'h0,        5'd4,  0, 32'h0,        1'b0, 0, 0, 1, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{2'd1, 32'h0000_0105, 32'h0,        5'd4,  0, 32'h0,        1'b1, 0, 0, 1, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{2'd0, 32'h0000_CAFE, 32'h0,        5'd9,  0, 32'h0,        1'b1, 0, 1, 2, 1'b0, 1'b0, 32'h0000_CAFE};
      tbl[6]  = '{2'd1, 32'h0000_0040, 32'h0,        5'd0,  1, 32'h0000_0011, 1'b0, 2, 0, 4, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{2'd1, 32'h0000_0300, 32'h0,        5'd8, 255, 32'h1234_5678, 1'b0, 4, 0, 5, 1'b1, 1'b1, 32'h0};
      tbl[8]  = '{2'd3, 32'h0000_0000, 32'h0,        5'd6,  0, 32'h0,        1'b0, 0, 0, 1, 1'b1, 1'b0, 32'h0};
      tbl[9]  = '{2'd2, 32'h0000_0201, 32'h1111_2222, 5'd2, 0, 32'h0,        1'b0, 0, 0, 1, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{2'd0, 32'hFFFF_FFFF, 32'h0,        5'd31, 0, 32'h0,        1'b1, 0, 1, 2, 1'b0, 1'b0, 32'hFFFF_FFFF};
      tbl[11] = '{2'd2, 32'h0000_0010, 32'h0BAD_F00D, 5'd1, 2, 32'h0,        1'b0, 3, 0, 4, 1'b0, 1'b0, 32'h0};

      rst_n = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_result = '0; ex_wdata = '0;
      ex_rd = '0; mem_ready = 1'b0; mem_rdata = '0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ex_ready", 32'(ex_ready), 32'd1);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset rf_we", 32'(rf_we), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset wb_dm", wb_dm, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // err_clr with no instruction clears a set error
      v = model('{2'd3, 32'h8, 32'h0, 5'd1, 0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0}, errm);
      run_vec("rsv_before_clr", v);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr alone", 32'(err), 32'd0);
      errm = 1'b0;

      // Random transactions against the transaction-level model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom % 2 == 0) r[1:0] = 2'b00;
         v = model('{2'($urandom), r, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom,
                     1'($urandom % 4 == 0), 0, 0, 0, 1'b0, 1'b0, 32'h0}, errm);
         run_vec($sformatf("rnd%0d", i), v);
      end

      // Reset in the middle of an access
      ex_valid = 1'b1; ex_op = 2'd1; ex_result = 32'h80; ex_rd = 5'd2; ex_wdata = '0;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0; mem_ready = 1'b0;
      chk("midrst req_active", 32'(mem_req), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst mem_req", 32'(mem_req), 32'd0);
      chk("midrst ex_ready", 32'(ex_ready), 32'd1);
      chk("midrst rf_we", 32'(rf_we), 32'd0);
      chk("midrst mem_addr", mem_addr, 32'd0);
      chk("midrst wb_result", wb_result, 32'd0);
      chk("midrst wb_dm", wb_dm, 32'd0);
      chk("midrst wb_sel", 32'(wb_sel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      errm = 1'b0;
      v = model('{2'd0, 32'h0000_0777, 32'h0, 5'd12, 0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0}, errm);
      run_vec("post_reset_alu", v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
